icache_set_assoc: RTL and testbench
===================================

// Module: icache_set_assoc
// PURPOSE
//  Parametrised set-associative instruction cache between instruction fetcher (IF) and memory controller (MC).
//  Successor of the direct-mapped IC: configurable ways, line size and sets; round-robin replacement.
//  Adds whole-cache invalidate (fence.i) and misprediction flush, which drops in-flight hit/refill responses to IF.
// PARAMETERS
//  ADDR_WIDTH   32  byte-address width
//  BLOCK_WIDTH  1   log2(32-bit words per line); line = 32<<BLOCK_WIDTH bits
//  INDEX_WIDTH  6   log2(sets)
//  WAY_WIDTH    1   log2(ways); legal 0..2 (1/2/4 ways)
//  TAG_WIDTH    ADDR_WIDTH-INDEX_WIDTH-BLOCK_WIDTH-2 (derived, localparam)
// PORTS
//  clk_in             in   1                 clock, posedge
//  rst_n_in           in   1                 async reset, active-low
//  rdy_in             in   1                 global enable; 0 = freeze all state (reset still acts)
//  IF2IC_en           in   1                 fetch request valid (level, held by IF until IC2IF_en)
//  IF2IC_addr         in   ADDR_WIDTH        fetch address, [1:0]=0
//  IC2IF_en           out  1                 one-cycle pulse: IC2IF_data valid
//  IC2IF_data         out  32                instruction word
//  IC2MC_en           out  1                 refill request, held high until MC2IC_en
//  IC2MC_addr         out  ADDR_WIDTH        line-aligned refill address (low BLOCK_WIDTH+2 bits 0)
//  MC2IC_en           in   1                 one-cycle pulse: MC2IC_block valid
//  MC2IC_block        in   32<<BLOCK_WIDTH   refill line, word 0 in [31:0]
//  ROB2IC_flush       in   1                 mispredict: abort current fetch
//  ROB2IC_invalidate  in   1                 fence.i: clear all valid bits
// BEHAVIOUR
//  Reset (rst_n_in=0, async): IC2IF_en=0, IC2IF_data=0, IC2MC_en=0, IC2MC_addr=0, all valid=0, rr pointers=0, state=IDLE.
//  Address split: offset=addr[BLOCK_WIDTH+1:2], index=addr[INDEX_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2], tag=upper TAG_WIDTH bits.
//  States: IDLE, REFILL, DROP. Priority per cycle: reset > flush/invalidate > rdy_in=0 hold > normal.
//  IDLE: IF2IC_en=1 and IC2IF_en=0 -> look up all ways of index.
//   hit  -> next cycle IC2IF_en=1, data=line word[offset]; latency 1. Cycle after a pulse, no lookup (IF drops en).
//   miss -> IC2MC_en=1, IC2MC_addr=addr with low BLOCK_WIDTH+2 bits cleared; latch index/tag/offset; ->REFILL.
//  REFILL: wait MC2IC_en. On it: write line+tag into victim way, set valid, IC2MC_en=0,
//   IC2IF_en=1 with word[latched offset] same edge (critical-word forward), ->IDLE.
//  Victim: lowest-numbered invalid way; if all valid, rr_ptr[index]; rr_ptr[index] += 1 (mod ways) on every fill.
//  Multi-hit impossible by construction (fill only on miss); not checked.
//  ROB2IC_flush=1:
//   IDLE: IC2IF_en=0 next cycle (pending hit response cancelled); no lookup that cycle.
//   REFILL: IC2MC_en stays 1 (MC transaction cannot be aborted), ->DROP.
//   DROP: wait MC2IC_en; line is still written into cache (address valid), no IC2IF_en pulse; ->IDLE.
//   Flush and MC2IC_en same cycle in REFILL: fill line, suppress IC2IF_en, ->IDLE.
//  ROB2IC_invalidate=1: all valid bits and rr pointers cleared that edge; implies flush semantics above,
//   except DROP completion does NOT set valid (line discarded, stale pre-fence data).
//   A refill in flight at invalidate therefore always completes as discard.
//  rdy_in=0: no state, output or array changes; IC2IF_en pulse is extended until first rdy cycle.
//  MC2IC_en in IDLE: ignored (protocol error; assertion in bench).
//  IC2MC_addr changes only on IDLE->REFILL transition.
// STRUCTURE
//  Shared package (ic_pkg): ic_state_e {IDLE,REFILL,DROP}; localparams TAG_WIDTH, WORDS, WAYS, SETS.
//  One sub-module: ic_tag_way (per-way tag/valid/data arrays, combinational read, write port, clear_all); generated WAYS times.
//  Top holds FSM, victim select, rr pointers, hit mux.
// TESTING
//  Cold miss: fetch 0x0000_1004 -> IC2MC_addr=0x0000_1000; MC returns {0x2222,0x1111} -> IC2IF_data=0x2222 with IC2IF_en same edge.
//  Hit after fill: fetch 0x0000_1000 -> IC2IF_en 1 cycle later, data 0x1111, no IC2MC_en.
//  Conflict (WAY_WIDTH=1, INDEX_WIDTH=6): fill 0x1000, 0x1200, 0x1400 same set -> third evicts way0 (0x1000); 0x1200 still hits.
//  Flush mid-refill: miss 0x2000, flush 2 cycles later, MC responds -> no IC2IF_en; later fetch 0x2000 hits.
//  fence.i mid-refill: invalidate during REFILL -> MC response discarded; fetch 0x1200 misses afterwards.
//  rdy_in low for 3 cycles across hit pulse -> IC2IF_en held, data unchanged, single accepted response.

Source files
------------

// File: rtl/ic_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
package ic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DROP
    } ic_state_e;

    // Geometry of the default configuration (32-bit address, 2 words/line, 64 sets, 2 ways).
    localparam int unsigned TAG_WIDTH = 23;
    localparam int unsigned WORDS     = 2;
    localparam int unsigned WAYS      = 2;
    localparam int unsigned SETS      = 64;

endpackage

// File: rtl/ic_tag_way.sv
// One cache way: tag, valid and line storage with combinational read and one write port.
module ic_tag_way #(
    parameter int unsigned TAG_WIDTH   = 23,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned LINE_WIDTH  = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_all_i,
    input  logic [INDEX_WIDTH-1:0] rd_index_i,
    output logic                   rd_valid_o,
    output logic [TAG_WIDTH-1:0]   rd_tag_o,
    output logic [LINE_WIDTH-1:0]  rd_data_o,
    input  logic                   we_i,
    input  logic [INDEX_WIDTH-1:0] wr_index_i,
    input  logic [TAG_WIDTH-1:0]   wr_tag_i,
    input  logic [LINE_WIDTH-1:0]  wr_data_i
);

    localparam int unsigned Sets = 1 << INDEX_WIDTH;

    logic [Sets-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [Sets];
    logic [LINE_WIDTH-1:0] data_q [Sets];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (clear_all_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are qualified by valid_q.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache: FSM, hit mux, victim choice and round-robin pointers.
module icache_set_assoc
    import ic_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BLOCK_WIDTH = 1,
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned WAY_WIDTH   = 1
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           rdy_in,
    input  logic                           IF2IC_en,
    input  logic [ADDR_WIDTH-1:0]          IF2IC_addr,
    output logic                           IC2IF_en,
    output logic [31:0]                    IC2IF_data,
    output logic                           IC2MC_en,
    output logic [ADDR_WIDTH-1:0]          IC2MC_addr,
    input  logic                           MC2IC_en,
    input  logic [(32<<BLOCK_WIDTH)-1:0]   MC2IC_block,
    input  logic                           ROB2IC_flush,
    input  logic                           ROB2IC_invalidate
);

    localparam int unsigned TAG_W  = ADDR_WIDTH - INDEX_WIDTH - BLOCK_WIDTH - 2;
    localparam int unsigned LINE_W = 32 << BLOCK_WIDTH;
    localparam int unsigned N_WAYS = 1 << WAY_WIDTH;
    localparam int unsigned N_SETS = 1 << INDEX_WIDTH;
    localparam int unsigned WAY_W  = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

    ic_state_e               state_q, state_d;
    logic                    ic2if_en_q, ic2if_en_d;
    logic [31:0]             ic2if_data_q, ic2if_data_d;
    logic                    ic2mc_en_q, ic2mc_en_d;
    logic [ADDR_WIDTH-1:0]   ic2mc_addr_q, ic2mc_addr_d;
    logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [BLOCK_WIDTH-1:0]  off_q, off_d;
    logic                    discard_q, discard_d;
    logic [WAY_W-1:0]        rr_q [N_SETS];

    logic [BLOCK_WIDTH-1:0]  req_off;
    logic [INDEX_WIDTH-1:0]  req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_WIDTH-1:0]  rd_idx;
    logic [N_WAYS-1:0]       rd_valid, hit_vec, way_we;
    logic [TAG_W-1:0]        rd_tag  [N_WAYS];
    logic [LINE_W-1:0]       rd_data [N_WAYS];
    logic [LINE_W-1:0]       hit_data;
    logic [WAY_W-1:0]        victim, rr_next;
    logic                    fill_we, clear_all, abort;
    logic                    unused_addr;

    function automatic logic [31:0] pick_word(input logic [LINE_W-1:0]      line,
                                              input logic [BLOCK_WIDTH-1:0] off);
        return line[{off, 5'b00000} +: 32];
    endfunction

    assign req_off     = IF2IC_addr[BLOCK_WIDTH+1:2];
    assign req_idx     = IF2IC_addr[INDEX_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2];
    assign req_tag     = IF2IC_addr[ADDR_WIDTH-1:ADDR_WIDTH-TAG_W];
    assign unused_addr = ^IF2IC_addr[1:0];
    // Outside IDLE the arrays are looked up at the latched refill index for victim selection.
    assign rd_idx      = (state_q == IDLE) ? req_idx : idx_q;
    assign abort       = ROB2IC_flush | ROB2IC_invalidate;
    assign clear_all   = ROB2IC_invalidate;

    for (genvar w = 0; w < N_WAYS; w++) begin : g_way
        ic_tag_way #(
            .TAG_WIDTH  (TAG_W),
            .INDEX_WIDTH(INDEX_WIDTH),
            .LINE_WIDTH (LINE_W)
        ) u_way (
            .clk_i      (clk_in),
            .rst_ni     (rst_n_in),
            .clear_all_i(clear_all),
            .rd_index_i (rd_idx),
            .rd_valid_o (rd_valid[w]),
            .rd_tag_o   (rd_tag[w]),
            .rd_data_o  (rd_data[w]),
            .we_i       (way_we[w]),
            .wr_index_i (idx_q),
            .wr_tag_i   (tag_q),
            .wr_data_i  (MC2IC_block)
        );
    end

    always_comb begin
        hit_data = '0;
        victim   = rr_q[idx_q];
        for (int w = 0; w < int'(N_WAYS); w++) begin
            hit_vec[w] = rd_valid[w] && (rd_tag[w] == req_tag);
            if (hit_vec[w]) hit_data = hit_data | rd_data[w];
        end
        for (int w = int'(N_WAYS) - 1; w >= 0; w--) begin
            if (!rd_valid[w]) victim = WAY_W'(w);
        end
        for (int w = 0; w < int'(N_WAYS); w++) begin
            way_we[w] = fill_we && (victim == WAY_W'(w));
        end
        rr_next = (rr_q[idx_q] == WAY_W'(N_WAYS - 1)) ? '0 : rr_q[idx_q] + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        ic2if_en_d   = ic2if_en_q;
        ic2if_data_d = ic2if_data_q;
        ic2mc_en_d   = ic2mc_en_q;
        ic2mc_addr_d = ic2mc_addr_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        off_d        = off_q;
        discard_d    = discard_q;
        fill_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (abort) begin
                    ic2if_en_d = 1'b0;
                end else if (rdy_in) begin
                    ic2if_en_d = 1'b0;
                    if (IF2IC_en && !ic2if_en_q) begin
                        if (|hit_vec) begin
                            ic2if_en_d   = 1'b1;
                            ic2if_data_d = pick_word(hit_data, req_off);
                        end else begin
                            ic2mc_en_d   = 1'b1;
                            ic2mc_addr_d = {IF2IC_addr[ADDR_WIDTH-1:BLOCK_WIDTH+2],
                                            {(BLOCK_WIDTH+2){1'b0}}};
                            idx_d        = req_idx;
                            tag_d        = req_tag;
                            off_d        = req_off;
                            discard_d    = 1'b0;
                            state_d      = REFILL;
                        end
                    end
                end
            end
            REFILL: begin
                if (abort) begin
                    ic2if_en_d = 1'b0;
                    if (MC2IC_en) begin
                        fill_we    = !ROB2IC_invalidate;
                        ic2mc_en_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        discard_d = ROB2IC_invalidate;
                        state_d   = DROP;
                    end
                end else if (rdy_in && MC2IC_en) begin
                    fill_we      = 1'b1;
                    ic2mc_en_d   = 1'b0;
                    ic2if_en_d   = 1'b1;
                    ic2if_data_d = pick_word(MC2IC_block, off_q);
                    state_d      = IDLE;
                end
            end
            DROP: begin
                if (ROB2IC_invalidate) discard_d = 1'b1;
                if (MC2IC_en && (rdy_in || abort)) begin
                    // Lines fetched before a fence.i may be stale and are not installed.
                    fill_we    = !(discard_q || ROB2IC_invalidate);
                    ic2mc_en_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            ic2if_en_q   <= 1'b0;
            ic2if_data_q <= '0;
            ic2mc_en_q   <= 1'b0;
            ic2mc_addr_q <= '0;
            idx_q        <= '0;
            tag_q        <= '0;
            off_q        <= '0;
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ic2if_en_q   <= ic2if_en_d;
            ic2if_data_q <= ic2if_data_d;
            ic2mc_en_q   <= ic2mc_en_d;
            ic2mc_addr_q <= ic2mc_addr_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            off_q        <= off_d;
            discard_q    <= discard_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < int'(N_SETS); s++) rr_q[s] <= '0;
        end else if (clear_all) begin
            for (int s = 0; s < int'(N_SETS); s++) rr_q[s] <= '0;
        end else if (fill_we) begin
            rr_q[idx_q] <= rr_next;
        end
    end

    assign IC2IF_en   = ic2if_en_q;
    assign IC2IF_data = ic2if_data_q;
    assign IC2MC_en   = ic2mc_en_q;
    assign IC2MC_addr = ic2mc_addr_q;

endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed self-checking bench for icache_set_assoc in its default 2-way, 64-set, 2-word geometry.
module tb_icache_set_assoc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        if_en = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ic2if_en;
    logic [31:0] ic2if_data;
    logic        ic2mc_en;
    logic [31:0] ic2mc_addr;
    logic        mc_en = 1'b0;
    logic [63:0] mc_block = '0;
    logic        flush = 1'b0;
    logic        inval = 1'b0;

    int checks = 0;
    int errors = 0;

    icache_set_assoc #(
        .ADDR_WIDTH (32),
        .BLOCK_WIDTH(1),
        .INDEX_WIDTH(6),
        .WAY_WIDTH  (1)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .rdy_in           (rdy),
        .IF2IC_en         (if_en),
        .IF2IC_addr       (if_addr),
        .IC2IF_en         (ic2if_en),
        .IC2IF_data       (ic2if_data),
        .IC2MC_en         (ic2mc_en),
        .IC2MC_addr       (ic2mc_addr),
        .MC2IC_en         (mc_en),
        .MC2IC_block      (mc_block),
        .ROB2IC_flush     (flush),
        .ROB2IC_invalidate(inval)
    );

    always #5 clk = ~clk;

    // MC must only respond to an outstanding refill request.
    always @(negedge clk) begin
        if (rst_n && mc_en && !ic2mc_en) begin
            errors++;
            $display("FAIL mc_protocol: MC2IC_en=1 while IC2MC_en=%0b", ic2mc_en);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full miss transaction; returns what was observed at request and at response.
    task automatic do_miss(input logic [31:0] addr, input logic [63:0] blk,
                           output logic mc_seen, output logic [31:0] mc_addr_seen,
                           output logic en_seen, output logic [31:0] data_seen);
        if_en = 1'b1; if_addr = addr;
        tick();
        mc_seen = ic2mc_en; mc_addr_seen = ic2mc_addr;
        if (ic2mc_en) begin
            mc_en = 1'b1; mc_block = blk;
        end
        tick();
        en_seen = ic2if_en; data_seen = ic2if_data;
        mc_en = 1'b0; if_en = 1'b0;
        tick();
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic en_seen,
                            output logic [31:0] data_seen, output logic mc_seen);
        if_en = 1'b1; if_addr = addr;
        tick();
        en_seen = ic2if_en; data_seen = ic2if_data; mc_seen = ic2mc_en;
        if_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (ic2if_en !== 1'b0) begin errors++; $display("FAIL reset_if_en: got %b want 0", ic2if_en); end
        checks++; if (ic2if_data !== 32'h0) begin errors++; $display("FAIL reset_if_data: got %h want 0", ic2if_data); end
        checks++; if (ic2mc_en !== 1'b0) begin errors++; $display("FAIL reset_mc_en: got %b want 0", ic2mc_en); end
        checks++; if (ic2mc_addr !== 32'h0) begin errors++; $display("FAIL reset_mc_addr: got %h want 0", ic2mc_addr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss();
        logic mc; logic [31:0] ma; logic en; logic [31:0] d;
        if_en = 1'b1; if_addr = 32'h0000_1004;
        tick();
        checks++; if (ic2mc_en !== 1'b1) begin errors++; $display("FAIL cold_mc_en: got %b want 1", ic2mc_en); end
        checks++; if (ic2mc_addr !== 32'h0000_1000) begin errors++; $display("FAIL cold_mc_addr: got %h want 00001000", ic2mc_addr); end
        tick(); tick();
        checks++; if (ic2mc_en !== 1'b1 || ic2if_en !== 1'b0) begin errors++; $display("FAIL cold_wait: got mc_en=%b if_en=%b want 1/0", ic2mc_en, ic2if_en); end
        mc_en = 1'b1; mc_block = 64'h0000_2222_0000_1111;
        tick();
        checks++; if (ic2if_en !== 1'b1 || ic2if_data !== 32'h2222) begin errors++; $display("FAIL cold_forward: got en=%b data=%h want 1/00002222", ic2if_en, ic2if_data); end
        checks++; if (ic2mc_en !== 1'b0) begin errors++; $display("FAIL cold_mc_drop: got %b want 0", ic2mc_en); end
        mc_en = 1'b0; if_en = 1'b0;
        tick();
        checks++; if (ic2if_en !== 1'b0) begin errors++; $display("FAIL cold_pulse_len: got %b want 0", ic2if_en); end
        do_fetch(32'h0000_1000, en, d, mc);
        checks++; if (en !== 1'b1 || d !== 32'h1111 || mc !== 1'b0) begin errors++; $display("FAIL hit_after_fill: got en=%b data=%h mc=%b want 1/00001111/0", en, d, mc); end
        ma = '0;
    endtask

    task automatic test_conflict();
        logic mc; logic [31:0] ma; logic en; logic [31:0] d;
        do_miss(32'h0000_1200, 64'h0000_00B2_0000_00B1, mc, ma, en, d);
        checks++; if (mc !== 1'b1 || ma !== 32'h1200 || d !== 32'hB1) begin errors++; $display("FAIL fill_1200: got mc=%b addr=%h data=%h want 1/00001200/000000b1", mc, ma, d); end
        do_miss(32'h0000_1400, 64'h0000_00C2_0000_00C1, mc, ma, en, d);
        checks++; if (mc !== 1'b1 || en !== 1'b1 || d !== 32'hC1) begin errors++; $display("FAIL fill_1400: got mc=%b en=%b data=%h want 1/1/000000c1", mc, en, d); end
        do_fetch(32'h0000_1204, en, d, mc);
        checks++; if (en !== 1'b1 || d !== 32'hB2 || mc !== 1'b0) begin errors++; $display("FAIL conflict_1200_hit: got en=%b data=%h mc=%b want 1/000000b2/0", en, d, mc); end
        do_fetch(32'h0000_1400, en, d, mc);
        checks++; if (en !== 1'b1 || d !== 32'hC1 || mc !== 1'b0) begin errors++; $display("FAIL conflict_1400_hit: got en=%b data=%h mc=%b want 1/000000c1/0", en, d, mc); end
        // 0x1000 was evicted from way 0, so it must miss; refill lands in way 1 (rr=1).
        do_miss(32'h0000_1000, 64'h0000_0A02_0000_0A01, mc, ma, en, d);
        checks++; if (mc !== 1'b1 || ma !== 32'h1000 || d !== 32'hA01) begin errors++; $display("FAIL conflict_1000_evicted: got mc=%b addr=%h data=%h want 1/00001000/00000a01", mc, ma, d); end
    endtask

    task automatic test_flush_idle();
        if_en = 1'b1; if_addr = 32'h0000_1400; flush = 1'b1;
        tick();
        checks++; if (ic2if_en !== 1'b0 || ic2mc_en !== 1'b0) begin errors++; $display("FAIL flush_idle: got if_en=%b mc_en=%b want 0/0", ic2if_en, ic2mc_en); end
        flush = 1'b0; if_en = 1'b0;
        tick();
    endtask

    task automatic test_flush_refill();
        logic en; logic [31:0] d; logic mc;
        if_en = 1'b1; if_addr = 32'h0000_2000;
        tick();
        checks++; if (ic2mc_en !== 1'b1 || ic2mc_addr !== 32'h2000) begin errors++; $display("FAIL flush_miss_req: got en=%b addr=%h want 1/00002000", ic2mc_en, ic2mc_addr); end
        tick();
        flush = 1'b1; if_en = 1'b0;
        tick();
        flush = 1'b0;
        checks++; if (ic2mc_en !== 1'b1) begin errors++; $display("FAIL flush_mc_held: got %b want 1", ic2mc_en); end
        tick();
        mc_en = 1'b1; mc_block = 64'h0000_00D2_0000_00D1;
        tick();
        checks++; if (ic2if_en !== 1'b0 || ic2mc_en !== 1'b0) begin errors++; $display("FAIL flush_drop: got if_en=%b mc_en=%b want 0/0", ic2if_en, ic2mc_en); end
        mc_en = 1'b0;
        tick();
        do_fetch(32'h0000_2000, en, d, mc);
        checks++; if (en !== 1'b1 || d !== 32'hD1 || mc !== 1'b0) begin errors++; $display("FAIL flush_line_kept: got en=%b data=%h mc=%b want 1/000000d1/0", en, d, mc); end
    endtask

    task automatic test_fence();
        logic mc; logic [31:0] ma; logic en; logic [31:0] d;
        if_en = 1'b1; if_addr = 32'h0000_3000;
        tick();
        inval = 1'b1; if_en = 1'b0;
        tick();
        inval = 1'b0;
        checks++; if (ic2mc_en !== 1'b1) begin errors++; $display("FAIL fence_mc_held: got %b want 1", ic2mc_en); end
        mc_en = 1'b1; mc_block = 64'h0000_00F2_0000_00F1;
        tick();
        checks++; if (ic2if_en !== 1'b0 || ic2mc_en !== 1'b0) begin errors++; $display("FAIL fence_discard: got if_en=%b mc_en=%b want 0/0", ic2if_en, ic2mc_en); end
        mc_en = 1'b0;
        tick();
        do_miss(32'h0000_3000, 64'h0000_00F4_0000_00F3, mc, ma, en, d);
        checks++; if (mc !== 1'b1 || d !== 32'hF3) begin errors++; $display("FAIL fence_3000_miss: got mc=%b data=%h want 1/000000f3", mc, d); end
        do_miss(32'h0000_1200, 64'h0000_00E2_0000_00E1, mc, ma, en, d);
        checks++; if (mc !== 1'b1 || ma !== 32'h1200 || en !== 1'b1 || d !== 32'hE1) begin errors++; $display("FAIL fence_1200_miss: got mc=%b addr=%h en=%b data=%h want 1/00001200/1/000000e1", mc, ma, en, d); end
    endtask

    task automatic test_rdy_hold();
        if_en = 1'b1; if_addr = 32'h0000_1200;
        tick();
        checks++; if (ic2if_en !== 1'b1 || ic2if_data !== 32'hE1) begin errors++; $display("FAIL rdy_hit: got en=%b data=%h want 1/000000e1", ic2if_en, ic2if_data); end
        rdy = 1'b0; if_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ic2if_en !== 1'b1 || ic2if_data !== 32'hE1 || ic2mc_en !== 1'b0) begin errors++; $display("FAIL rdy_hold_%0d: got en=%b data=%h mc=%b want 1/000000e1/0", i, ic2if_en, ic2if_data, ic2mc_en); end
        end
        rdy = 1'b1;
        tick();
        checks++; if (ic2if_en !== 1'b0 || ic2mc_en !== 1'b0) begin errors++; $display("FAIL rdy_release: got en=%b mc=%b want 0/0", ic2if_en, ic2mc_en); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_conflict();
        test_flush_idle();
        test_flush_refill();
        test_fence();
        test_rdy_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
